// File: rtl/cmac_tx_axis_arbiter_if.sv
// AXI-Stream bundle for the CMAC TX path (tdata/tkeep/tvalid/tlast/tready).
// The master drives the payload and the slave drives tready.
interface cmac_tx_axis_arbiter_if #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = DATA_W / 8
);
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/cmac_tx_axis_arbiter.sv
// Packet-granular round-robin arbiter sharing the CMAC 512-bit TX AXI-Stream
// port between the ERNIC TX stream (s0) and the packet generator (s1).
// Packets are never interleaved; one IDLE cycle separates consecutive packets.
// Also keeps per-source packet counters and a sticky over-length flag.
module cmac_tx_axis_arbiter #(
  parameter int DATA_W    = 512,
  parameter int KEEP_W    = 64,
  parameter int CNT_W     = 32,
  parameter int MAX_BEATS = 256
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tx_en,
  cmac_tx_axis_arbiter_if.slave      s0_axis,
  cmac_tx_axis_arbiter_if.slave      s1_axis,
  cmac_tx_axis_arbiter_if.master     m_axis,
  output logic                       m_axis_tuser,
  output logic [1:0]                 grant,
  output logic                       busy,
  output logic [CNT_W-1:0]           s0_pkt_cnt,
  output logic [CNT_W-1:0]           s1_pkt_cnt,
  output logic                       len_err
);

  localparam int BEAT_W = $clog2(MAX_BEATS) + 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state;
  logic                last;       // last-served source: 0 = s0, 1 = s1
  logic [BEAT_W-1:0]   beats;      // beats of the current packet, saturating

  logic                owner;
  logic [DATA_W-1:0]   sel_data;
  logic [KEEP_W-1:0]   sel_keep;
  logic                sel_valid;
  logic                sel_last;
  logic                xfer;
  logic                pick;

  assign owner        = grant[1];
  assign m_axis_tuser = 1'b0;

  // Source selection for a new grant: alternate when both request.
  assign pick = (s0_axis.tvalid && s1_axis.tvalid) ? ~last : s1_axis.tvalid;

  // Zero-latency pass-through of the granted source while in SEND; quiet otherwise.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    sel_data       = owner ? s1_axis.tdata  : s0_axis.tdata;
    sel_keep       = owner ? s1_axis.tkeep  : s0_axis.tkeep;
    sel_valid      = owner ? s1_axis.tvalid : s0_axis.tvalid;
    sel_last       = owner ? s1_axis.tlast  : s0_axis.tlast;
    m_axis.tdata   = '0;
    m_axis.tkeep   = '0;
    m_axis.tvalid  = 1'b0;
    m_axis.tlast   = 1'b0;
    s0_axis.tready = 1'b0;
    s1_axis.tready = 1'b0;
    if (state == SEND) begin
      m_axis.tdata   = sel_data;
      m_axis.tkeep   = sel_keep;
      m_axis.tvalid  = sel_valid;
      m_axis.tlast   = sel_last;
      s0_axis.tready = ~owner & m_axis.tready;
      s1_axis.tready =  owner & m_axis.tready;
    end
  end

  assign xfer = (state == SEND) && sel_valid && m_axis.tready;

  // Arbitration FSM, beat/packet counters and the over-length flag.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state      <= IDLE;
      grant      <= 2'b00;
      busy       <= 1'b0;
      last       <= 1'b1;
      beats      <= '0;
      s0_pkt_cnt <= '0;
      s1_pkt_cnt <= '0;
      len_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tx_en && (s0_axis.tvalid || s1_axis.tvalid)) begin
            grant <= pick ? 2'b10 : 2'b01;
            busy  <= 1'b1;
            state <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            if (sel_last) begin
              if (owner) s1_pkt_cnt <= s1_pkt_cnt + CNT_W'(1);
              else       s0_pkt_cnt <= s0_pkt_cnt + CNT_W'(1);
              last  <= owner;
              grant <= 2'b00;
              busy  <= 1'b0;
              beats <= '0;
              state <= IDLE;
            end else begin
              // Flag only; the over-length packet is still forwarded intact.
              if (beats == BEAT_W'(MAX_BEATS - 1)) len_err <= 1'b1;
              if (beats != '1) beats <= beats + BEAT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmac_tx_axis_arbiter.sv
// Directed self-checking bench for cmac_tx_axis_arbiter (built with MAX_BEATS=8).
module tb_cmac_tx_axis_arbiter;

  typedef struct {
    logic         src;
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
    int           cyc;
  } beat_t;

  logic        clk;
  logic        reset;
  logic        tx_en;
  logic        m_axis_tuser;
  logic [1:0]  grant;
  logic        busy;
  logic [31:0] s0_pkt_cnt;
  logic [31:0] s1_pkt_cnt;
  logic        len_err;

  int num_checks = 0;
  int num_fails  = 0;
  int cyc        = 0;

  beat_t q0[$];
  beat_t q1[$];
  beat_t rx[$];
  beat_t exp_q[$];

  cmac_tx_axis_arbiter_if #(.DATA_W(512), .KEEP_W(64)) s0_if ();
  cmac_tx_axis_arbiter_if #(.DATA_W(512), .KEEP_W(64)) s1_if ();
  cmac_tx_axis_arbiter_if #(.DATA_W(512), .KEEP_W(64)) m_if ();

  cmac_tx_axis_arbiter #(
    .DATA_W(512), .KEEP_W(64), .CNT_W(32), .MAX_BEATS(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_en        (tx_en),
    .s0_axis      (s0_if),
    .s1_axis      (s1_if),
    .m_axis       (m_if),
    .m_axis_tuser (m_axis_tuser),
    .grant        (grant),
    .busy         (busy),
    .s0_pkt_cnt   (s0_pkt_cnt),
    .s1_pkt_cnt   (s1_pkt_cnt),
    .len_err      (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic beat_t mk_beat(input int src, input int id, input int b, input int n);
    beat_t t;
    t.src  = src[0];
    t.data = {16{8'(src), 8'(id), 16'(b)}};
    t.last = (b == n - 1);
    t.keep = t.last ? 64'h0000_0000_FFFF_FFFF : '1;
    t.cyc  = 0;
    return t;
  endfunction

  // Queue a packet on a source and append it to the expected output stream.
  task automatic add_pkt(input int src, input int id, input int n);
    for (int b = 0; b < n; b++) begin
      if (src == 0) q0.push_back(mk_beat(src, id, b, n));
      else          q1.push_back(mk_beat(src, id, b, n));
      exp_q.push_back(mk_beat(src, id, b, n));
    end
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx.size() < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (rx.size() < n) check("rx_timeout", rx.size(), n);
  endtask

  task automatic compare_stream(input string tag);
    int n;
    n = (rx.size() < exp_q.size()) ? rx.size() : exp_q.size();
    check({tag, "_beats"}, rx.size(), exp_q.size());
    for (int i = 0; i < n; i++) begin
      check({tag, "_data"}, rx[i].data, exp_q[i].data);
      check({tag, "_src_last_keep"}, {rx[i].src, rx[i].last, rx[i].keep},
            {exp_q[i].src, exp_q[i].last, exp_q[i].keep});
    end
    rx.delete();
    exp_q.delete();
  endtask

  // Source 0 driver: present queue head, pop on handshake.
  initial begin
    s0_if.tvalid = 1'b0; s0_if.tdata = '0; s0_if.tkeep = '0; s0_if.tlast = 1'b0;
    forever begin
      @(posedge clk);
      if (s0_if.tvalid && s0_if.tready && q0.size() > 0) void'(q0.pop_front());
      #1;
      s0_if.tvalid = (q0.size() > 0);
      if (q0.size() > 0) begin
        s0_if.tdata = q0[0].data; s0_if.tkeep = q0[0].keep; s0_if.tlast = q0[0].last;
      end
    end
  end

  // Source 1 driver.
  initial begin
    s1_if.tvalid = 1'b0; s1_if.tdata = '0; s1_if.tkeep = '0; s1_if.tlast = 1'b0;
    forever begin
      @(posedge clk);
      if (s1_if.tvalid && s1_if.tready && q1.size() > 0) void'(q1.pop_front());
      #1;
      s1_if.tvalid = (q1.size() > 0);
      if (q1.size() > 0) begin
        s1_if.tdata = q1[0].data; s1_if.tkeep = q1[0].keep; s1_if.tlast = q1[0].last;
      end
    end
  end

  // Output monitor: record every transferred beat with its owner and cycle.
  initial begin
    beat_t t;
    forever begin
      @(posedge clk);
      cyc++;
      if (m_if.tvalid && m_if.tready) begin
        t.src  = grant[1];
        t.data = m_if.tdata;
        t.keep = m_if.tkeep;
        t.last = m_if.tlast;
        t.cyc  = cyc;
        rx.push_back(t);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b1;
    tx_en = 1'b1;
    m_if.tready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_m_tvalid", m_if.tvalid, 0);
    check("rst_m_tlast", m_if.tlast, 0);
    check("rst_m_tdata", m_if.tdata, 0);
    check("rst_m_tkeep", m_if.tkeep, 0);
    check("rst_m_tuser", m_axis_tuser, 0);
    check("rst_s0_tready", s0_if.tready, 0);
    check("rst_s1_tready", s1_if.tready, 0);
    check("rst_grant", grant, 2'b00);
    check("rst_busy", busy, 0);
    check("rst_cnts", {s0_pkt_cnt, s1_pkt_cnt}, 0);
    check("rst_len_err", len_err, 0);

    // Single source: three 9-beat s0 packets
    for (int p = 0; p < 3; p++) add_pkt(0, p, 9);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    wait_rx(27, 200);
    if (rx.size() >= 27) begin
      check("single_back_to_back", rx[1].cyc - rx[0].cyc, 1);
      check("single_gap_1", rx[9].cyc - rx[8].cyc, 2);
      check("single_gap_2", rx[18].cyc - rx[17].cyc, 2);
    end
    compare_stream("single");
    @(negedge clk);
    check("single_s0_cnt", s0_pkt_cnt, 3);
    check("single_s1_cnt", s1_pkt_cnt, 0);

    // Contention: s0 2-beat packets vs s1 5-beat packets, strict alternation
    @(negedge clk) reset = 1'b1;
    q0.delete(); q1.delete(); rx.delete(); exp_q.delete();
    for (int p = 0; p < 5; p++) begin
      add_pkt(0, 10 + p, 2);
      add_pkt(1, 20 + p, 5);
    end
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    wait_rx(35, 300);
    @(negedge clk);
    compare_stream("rr");
    check("rr_s0_cnt", s0_pkt_cnt, 5);
    check("rr_s1_cnt", s1_pkt_cnt, 5);

    // Backpressure: random m_axis_tready during a 9-beat s1 packet
    @(negedge clk) add_pkt(1, 30, 9);
    @(posedge clk);
    @(posedge clk);
    #1;
    k = 0;
    while (rx.size() < 9 && k < 200) begin
      m_if.tready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("bp_s1_tready", s1_if.tready, m_if.tready);
      check("bp_s0_tready", s0_if.tready, 0);
      @(posedge clk); #1;
      k++;
    end
    if (rx.size() < 9) check("bp_timeout", rx.size(), 9);
    m_if.tready = 1'b1;
    compare_stream("bp");
    @(negedge clk);
    check("bp_s1_cnt", s1_pkt_cnt, 6);

    // tx_en gating: drop at beat 4 of s0 packet while s1 waits
    add_pkt(0, 40, 9);
    add_pkt(1, 41, 3);
    wait_rx(4, 50);
    tx_en = 1'b0;
    wait_rx(9, 50);
    repeat (4) begin
      @(negedge clk);
      check("gate_grant_idle", grant, 2'b00);
      check("gate_busy_idle", busy, 0);
    end
    check("gate_no_beats", rx.size(), 9);
    @(posedge clk); #1;
    tx_en = 1'b1;
    @(negedge clk);
    check("gate_grant_before_edge", grant, 2'b00);
    @(negedge clk);
    check("gate_grant_s1", grant, 2'b10);
    wait_rx(12, 50);
    compare_stream("gate");

    // Over-length: 8-beat packet is legal, 10-beat packet flags at beat 8
    @(negedge clk) reset = 1'b1;
    q0.delete(); q1.delete(); rx.delete(); exp_q.delete();
    add_pkt(0, 50, 8);
    add_pkt(0, 51, 10);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    k = 0;
    while (rx.size() < 18 && k < 60) begin
      @(negedge clk);
      check("len_err", len_err, rx.size() >= 16);
      k++;
    end
    if (rx.size() < 18) check("len_timeout", rx.size(), 18);
    compare_stream("len");
    @(negedge clk);
    check("len_s0_cnt", s0_pkt_cnt, 2);
    check("len_err_sticky", len_err, 1);

    // Reset mid-packet, then both valid: s0 must win first
    add_pkt(1, 60, 6);
    wait_rx(3, 50);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_m_tvalid", m_if.tvalid, 0);
    check("mid_rst_grant", grant, 2'b00);
    check("mid_rst_s1_tready", s1_if.tready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cnts", {s0_pkt_cnt, s1_pkt_cnt}, 0);
    check("mid_rst_len_err", len_err, 0);
    q0.delete(); q1.delete();
    repeat (2) @(negedge clk);
    rx.delete(); exp_q.delete();
    add_pkt(0, 61, 2);
    add_pkt(1, 62, 2);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    check("post_rst_grant_s0", grant, 2'b01);
    wait_rx(4, 50);
    compare_stream("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_fails);
    $finish;
  end

endmodule

// File: doc/cmac_tx_axis_arbiter.md
# cmac_tx_axis_arbiter

Packet-granular two-input arbiter for the CMAC 512-bit TX AXI-Stream port (`tx_axis_*`). It shares the single CMAC transmit interface between two requesters: source 0 is the ERNIC transmit stream and source 1 is the AXIS packet generator. It never interleaves beats of different packets, and it alternates between sources round-robin. It also counts packets per source and flags over-length packets.

## Interface
Parameters:
- `DATA_W`, 512, tdata width in bits
- `KEEP_W`, 64, tkeep width; equals `DATA_W/8`
- `CNT_W`, 32, width of each per-source packet counter
- `MAX_BEATS`, 256, maximum legal packet length in beats; `BEAT_W = $clog2(MAX_BEATS)+1`

Ports:
- `clk`  in  1  CMAC TX user clock (txusrclk2); all logic on rising edge
- `reset`  in  1  asynchronous, active-high; connected to `usr_tx_reset`
- `tx_en`  in  1  when 1, new packet grants are allowed; a packet in flight always completes
- `s0_axis_tdata` / `s0_axis_tkeep` / `s0_axis_tvalid` / `s0_axis_tlast`  in  DATA_W/KEEP_W/1/1  source 0 (ERNIC)
- `s0_axis_tready`  out  1  source 0 ready
- `s1_axis_tdata` / `s1_axis_tkeep` / `s1_axis_tvalid` / `s1_axis_tlast`  in  DATA_W/KEEP_W/1/1  source 1 (packet generator)
- `s1_axis_tready`  out  1  source 1 ready
- `m_axis_tdata` / `m_axis_tkeep` / `m_axis_tvalid` / `m_axis_tlast`  out  DATA_W/KEEP_W/1/1  to CMAC `tx_axis_*`
- `m_axis_tuser`  out  1  tied 0; the arbiter never signals errors to the MAC
- `m_axis_tready`  in  1  CMAC `tx_axis_tready`
- `grant`  out  2  one-hot owner of the output (`01` = s0, `10` = s1, `00` = none)
- `busy`  out  1  1 while in SEND
- `s0_pkt_cnt`, `s1_pkt_cnt`  out  CNT_W  completed packets per source
- `len_err`  out  1  sticky; set when a packet exceeds `MAX_BEATS` beats

## Operation
- FSM states: IDLE and SEND. Register `last` holds the last-served source; its reset value is 1, so source 0 wins first.
- IDLE behaviour:
  - All outputs are quiet: `m_axis_tvalid=0`, `s*_tready=0`.
  - If `tx_en=1` and any `s*_tvalid=1`: if both sources are valid, select the source opposite `last`; otherwise select the single valid source.
  - Register the selection into `grant` and move to SEND.
- SEND behaviour (pure combinational pass-through of the selected source):
  - `m_axis_{tdata,tkeep,tvalid,tlast}` = selected `s*_axis_*`.
  - Selected `s*_tready = m_axis_tready`; the non-selected `tready = 0`.
- Beat transfer: `m_axis_tvalid & m_axis_tready` in SEND. The beat counter `beats` (BEAT_W bits, saturating) increments on each beat.
- Last beat (transfer with `tlast=1`):
  - Increment the owner's packet counter; it wraps modulo 2^CNT_W.
  - Set `last = owner`, `grant = 00`, clear `beats`, return to IDLE.
- Length check: if a beat transfers with `tlast=0` while `beats == MAX_BEATS-1`, set `len_err`. Forwarding continues unchanged; the packet is not truncated. `len_err` clears only on reset.
- `tx_en` is sampled only in IDLE. Deasserting it mid-packet has no effect until that packet's `tlast`.
- A source's `tvalid` toggling while it is not granted is ignored. Non-granted sources see `tready=0` and must hold their data (standard AXIS).
- Asynchronous reset, including mid-packet:
  - Forces IDLE, `grant=00`, `busy=0`, `last=1`, `beats=0`, both counters 0, `len_err=0`.
  - All `s*_tready` and `m_axis_tvalid` fall to 0 immediately. A partial packet is abandoned; the CMAC is in reset too.

## Timing
- Reset values: `m_axis_tvalid=0`, `m_axis_tlast=0`, `m_axis_tdata/tkeep=0`, `m_axis_tuser=0`, `s0/s1_tready=0`, `grant=00`, `busy=0`, counters 0, `len_err=0`.
- Arbitration latency: one cycle. A request seen in IDLE at edge N gives `grant`/`busy` valid after edge N, and the first beat can transfer in cycle N+1.
- Data path latency: zero cycles; tdata, tkeep, tvalid, tlast and tready are combinational in SEND.
- Inter-packet gap: exactly one IDLE cycle after every `tlast` beat. Peak throughput is L/(L+1) beats per cycle for L-beat packets.
- Counters and `len_err` update on the edge of the qualifying beat and are visible the next cycle.
- Backpressure: while `m_axis_tready=0` the selected `tready` is 0. Outputs follow the source; the source must hold stable.

## Test plan
- Single source: after reset, s0 sends 3 packets of 9 beats with `m_axis_tready=1` and s1 idle. Expect 27 beats out matching s0 bit-exact, `grant=01` during each packet, one-cycle gap after each, `s0_pkt_cnt=3`, `s1_pkt_cnt=0`.
- Contention round-robin: both sources continuously valid, s0 packets of 2 beats, s1 packets of 5 beats. Expect grant order s0, s1, s0, s1; no interleaving; after 10 packets both counters equal 5.
- Backpressure: random `m_axis_tready` (50%) during a 9-beat s1 packet. Expect s1 `tready` to mirror `m_axis_tready`, output to match the input sequence exactly, and s0 `tready=0` throughout.
- tx_en gating: drop `tx_en` at beat 4 of a 9-beat s0 packet while s1 is valid. Expect the s0 packet to complete, then IDLE with no grant while `tx_en=0`, then s1 granted one cycle after `tx_en` returns to 1.
- Over-length: `MAX_BEATS=8`, s0 sends 10 beats with `tlast` on beat 10. Expect `len_err=1` from the cycle after beat 8, all 10 beats forwarded, `s0_pkt_cnt=1`.
- Reset mid-packet: assert `reset` at beat 3 of an s1 packet. Expect `m_axis_tvalid=0` and `grant=00` without waiting for a clock edge, counters 0. After release with both sources valid, s0 is granted first.
